char_assembler: RTL and testbench

CHAR_ASSEMBLER -- requirements
Module: char_assembler

---
 rtl/char_pkg.sv | 21 ++
 rtl/char_bit_counter.sv | 22 ++
 rtl/char_assembler.sv | 116 +++++++++++
 tb/tb_char_assembler.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/char_pkg.sv
// Shared types and helpers for the serial character assembler.
package char_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SHIFT  = 2'd1,
      PARITY = 2'd2
   } state_t;

   localparam int ERR_CODE_DEF = 2;

   // Width needed to hold 0..v-1; never narrower than one bit.
   function automatic int clog2w(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      if (r == 0) r = 1;
      return r;
   endfunction

endpackage

// File: rtl/char_bit_counter.sv
// Bit counter for the assembler: clear, increment, terminal-count flag at MAX.
module char_bit_counter #(
   parameter int MAX = 6,
   parameter int W   = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   output logic tc
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (reset || clr) cnt <= '0;
      else if (inc)     cnt <= cnt + 1'b1;
   end

   assign tc = (cnt == W'(MAX));

endmodule

// File: rtl/char_assembler.sv
// Serial-to-parallel character assembler with optional parity check and
// line-error substitution.
module char_assembler
   import char_pkg::*;
#(
   parameter int                DATA_W     = 7,
   parameter int                MSB_FIRST  = 0,
   parameter int                PARITY_EN  = 0,
   parameter int                PARITY_ODD = 0,
   parameter logic [DATA_W-1:0] ERR_CODE   = DATA_W'(ERR_CODE_DEF)
) (
   input  logic              clk_2,
   input  logic              reset,
   input  logic              rxd,
   input  logic              start,
   input  logic              write_char,
   input  logic              error,
   output logic [DATA_W-1:0] char,
   output logic              char_valid,
   output logic              char_err,
   output logic              busy
);

   localparam int CW = clog2w(DATA_W);

   state_t            state, state_nxt;
   logic [DATA_W-1:0] sr, sr_shift, char_nxt;
   logic              par_acc;
   logic              cnt_clr, cnt_inc, tc;
   logic              clr_sr, shift, ld_char, err_nxt;

   assign sr_shift = (MSB_FIRST != 0) ? {sr[DATA_W-2:0], rxd}
                                      : {rxd, sr[DATA_W-1:1]};
   assign busy     = (state != IDLE);

   char_bit_counter #(.MAX(DATA_W-1), .W(CW)) u_cnt (
      .clk   (clk_2),
      .reset (reset),
      .clr   (cnt_clr),
      .inc   (cnt_inc),
      .tc    (tc)
   );

   always_ff @(posedge clk_2) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Priority is error, then start, then the bit strobe.
   always_comb begin
      state_nxt = state;
      cnt_clr   = 1'b0;
      cnt_inc   = 1'b0;
      clr_sr    = 1'b0;
      shift     = 1'b0;
      ld_char   = 1'b0;
      char_nxt  = sr_shift;
      err_nxt   = 1'b0;
      if (error) begin
         state_nxt = IDLE;
         cnt_clr   = 1'b1;
         ld_char   = 1'b1;
         char_nxt  = ERR_CODE;
         err_nxt   = 1'b1;
      end else if (start) begin
         state_nxt = SHIFT;
         cnt_clr   = 1'b1;
         clr_sr    = 1'b1;
      end else if (write_char) begin
         case (state)
            SHIFT: begin
               shift   = 1'b1;
               cnt_inc = 1'b1;
               if (tc) begin
                  cnt_clr = 1'b1;
                  if (PARITY_EN != 0) begin
                     state_nxt = PARITY;
                  end else begin
                     state_nxt = IDLE;
                     ld_char   = 1'b1;
                  end
               end
            end
            PARITY: begin
               state_nxt = IDLE;
               ld_char   = 1'b1;
               char_nxt  = sr;
               err_nxt   = par_acc ^ rxd ^ (PARITY_ODD != 0);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_2) begin
      if (reset) begin
         sr         <= '0;
         par_acc    <= 1'b0;
         char       <= '0;
         char_valid <= 1'b0;
         char_err   <= 1'b0;
      end else begin
         char_valid <= ld_char;
         char_err   <= ld_char & err_nxt;
         if (ld_char) char <= char_nxt;
         if (clr_sr) begin
            sr      <= '0;
            par_acc <= 1'b0;
         end else if (shift) begin
            sr      <= sr_shift;
            par_acc <= par_acc ^ rxd;
         end
      end
   end

endmodule

// File: tb/tb_char_assembler.sv
// Directed bench: three assembler configurations (LSB-first, MSB-first 8-bit,
// even parity) driven one at a time from a single stimulus sequence.
module tb_char_assembler;

   logic       clk_2 = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] st = '0, wc = '0, rx = '0, er = '0;
   logic [2:0] cv, ce, bz;
   logic [6:0] char7, charp;
   logic [7:0] char8;

   int checks = 0;
   int errors = 0;
   int pc0 = 0;
   int pc0_base;

   always #5 clk_2 = ~clk_2;

   char_assembler u_lsb (
      .clk_2(clk_2), .reset(reset), .rxd(rx[0]), .start(st[0]),
      .write_char(wc[0]), .error(er[0]), .char(char7),
      .char_valid(cv[0]), .char_err(ce[0]), .busy(bz[0]));

   char_assembler #(.DATA_W(8), .MSB_FIRST(1)) u_msb (
      .clk_2(clk_2), .reset(reset), .rxd(rx[1]), .start(st[1]),
      .write_char(wc[1]), .error(er[1]), .char(char8),
      .char_valid(cv[1]), .char_err(ce[1]), .busy(bz[1]));

   char_assembler #(.PARITY_EN(1)) u_par (
      .clk_2(clk_2), .reset(reset), .rxd(rx[2]), .start(st[2]),
      .write_char(wc[2]), .error(er[2]), .char(charp),
      .char_valid(cv[2]), .char_err(ce[2]), .busy(bz[2]));

   always @(negedge clk_2) if (cv[0]) pc0++;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: inputs applied at negedge, outputs settle #1 after posedge.
   task automatic cyc(input int u, input bit s, input bit w, input bit d, input bit e);
      @(negedge clk_2);
      st[u] = s; wc[u] = w; rx[u] = d; er[u] = e;
      @(posedge clk_2);
      #1;
      st[u] = 1'b0; wc[u] = 1'b0; rx[u] = 1'b0; er[u] = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk_2);
      reset = 1'b1;
      @(posedge clk_2);
      #1;
      reset = 1'b0;
   endtask

   task automatic send_lsb(input int u, input logic [15:0] val, input int n);
      for (int i = 0; i < n; i++) cyc(u, 1'b0, 1'b1, val[i], 1'b0);
   endtask

   task automatic send_msb(input int u, input logic [15:0] val, input int n);
      for (int i = n - 1; i >= 0; i--) cyc(u, 1'b0, 1'b1, val[i], 1'b0);
   endtask

   initial begin
      do_reset();
      do_reset();
      chk("rst_char7", char7, 7'h00);
      chk("rst_char8", char8, 8'h00);
      chk("rst_valid", cv, 3'b000);
      chk("rst_err", ce, 3'b000);
      chk("rst_busy", bz, 3'b000);

      // write_char in IDLE is ignored
      send_lsb(0, 16'h7F, 3);
      chk("idle_wc_busy", bz[0], 1'b0);
      chk("idle_wc_valid", cv[0], 1'b0);

      // LSB-first 7'h21
      cyc(0, 1, 0, 0, 0);
      chk("lsb_busy", bz[0], 1'b1);
      send_lsb(0, 16'h21, 6);
      chk("lsb_mid_valid", cv[0], 1'b0);
      send_lsb(0, 16'h20, 1);
      chk("lsb_char", char7, 7'h21);
      chk("lsb_valid", cv[0], 1'b1);
      chk("lsb_err", ce[0], 1'b0);
      chk("lsb_busy_fall", bz[0], 1'b0);
      cyc(0, 0, 0, 0, 0);
      chk("lsb_valid_one", cv[0], 1'b0);
      chk("lsb_hold", char7, 7'h21);

      // MSB-first 8-bit, then a back-to-back frame with an asymmetric pattern
      cyc(1, 1, 0, 0, 0);
      send_msb(1, 16'hA5, 8);
      chk("msb_a5", char8, 8'hA5);
      chk("msb_a5_valid", cv[1], 1'b1);
      cyc(1, 1, 0, 0, 0);
      chk("b2b_start_busy", bz[1], 1'b1);
      chk("b2b_start_valid", cv[1], 1'b0);
      send_msb(1, 16'h1E, 8);
      chk("msb_1e", char8, 8'h1E);
      chk("msb_1e_valid", cv[1], 1'b1);

      // Even parity: 7'h21 has two ones
      cyc(2, 1, 0, 0, 0);
      send_lsb(2, 16'h21, 7);
      chk("par_wait_valid", cv[2], 1'b0);
      chk("par_wait_busy", bz[2], 1'b1);
      cyc(2, 0, 1, 1, 0);
      chk("par_bad_char", charp, 7'h21);
      chk("par_bad_err", {cv[2], ce[2]}, 2'b11);
      cyc(2, 1, 0, 0, 0);
      send_lsb(2, 16'h21, 7);
      cyc(2, 0, 1, 0, 0);
      chk("par_ok_err", {cv[2], ce[2]}, 2'b10);
      chk("par_ok_busy", bz[2], 1'b0);
      cyc(2, 1, 0, 0, 0);
      send_lsb(2, 16'h23, 7);
      cyc(2, 0, 1, 1, 0);
      chk("par_odd_wt", {charp, cv[2], ce[2]}, {7'h23, 2'b10});

      // Line error after 3 bits, then a clean frame
      cyc(0, 1, 0, 0, 0);
      send_lsb(0, 16'h07, 3);
      cyc(0, 0, 0, 0, 1);
      chk("err_char", char7, 7'h02);
      chk("err_flags", {cv[0], ce[0], bz[0]}, 3'b110);
      cyc(0, 0, 0, 0, 0);
      chk("err_one_cycle", {cv[0], ce[0]}, 2'b00);
      cyc(0, 1, 0, 0, 0);
      send_lsb(0, 16'h33, 7);
      chk("after_err", {char7, cv[0], ce[0]}, {7'h33, 2'b10});

      // Restart after 4 bits, then 7'h55: a single pulse
      cyc(0, 0, 0, 0, 0);
      pc0_base = pc0;
      cyc(0, 1, 0, 0, 0);
      send_lsb(0, 16'h0F, 4);
      cyc(0, 1, 0, 0, 0);
      chk("restart_valid", cv[0], 1'b0);
      send_lsb(0, 16'h55, 7);
      chk("restart_char", char7, 7'h55);
      cyc(0, 0, 0, 0, 0);
      chk("restart_pulses", 16'(pc0 - pc0_base), 16'd1);

      // Reset mid-frame: no pulse, outputs cleared, trailing bits ignored
      pc0_base = pc0;
      cyc(0, 1, 0, 0, 0);
      send_lsb(0, 16'h07, 3);
      do_reset();
      chk("midrst_clear", {char7, cv[0], ce[0], bz[0]}, {7'h00, 3'b000});
      send_lsb(0, 16'h0F, 4);
      cyc(0, 0, 0, 0, 0);
      chk("midrst_pulses", 16'(pc0 - pc0_base), 16'd0);
      chk("midrst_busy", bz[0], 1'b0);

      // error and start together: error wins
      cyc(0, 1, 0, 0, 0);
      send_lsb(0, 16'h03, 2);
      cyc(0, 1, 0, 0, 1);
      chk("err_vs_start", {char7, cv[0], ce[0], bz[0]}, {7'h02, 3'b110});

      // error beats the final bit strobe
      cyc(0, 1, 0, 0, 0);
      send_lsb(0, 16'h3F, 6);
      @(negedge clk_2);
      wc[0] = 1'b1; rx[0] = 1'b1; er[0] = 1'b1;
      @(posedge clk_2);
      #1;
      wc[0] = 1'b0; rx[0] = 1'b0; er[0] = 1'b0;
      chk("err_vs_bit", {char7, cv[0], ce[0], bz[0]}, {7'h02, 3'b110});

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
